// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the 2-way set-associative, write-back,
// write-allocate LC-3b cache. It reads hit/dirty/LRU status from the datapath
// and drives the array write enables, mux selects and both memory handshakes.
// Optional feature: define CACHE_PERF_CNT_EN to add saturating hit/miss counters
// (hit_cnt/miss_cnt ports, width CNT_WIDTH).
module cache_control
`ifdef CACHE_PERF_CNT_EN
#(
  parameter int CNT_WIDTH = 16
)
`endif
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       hit0,
  input  logic       hit1,
  input  logic       dirty0,
  input  logic       dirty1,
  input  logic       lru,
  input  logic       pmem_resp,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic [1:0] w_Data,
  output logic [1:0] w_Tag,
  output logic [1:0] w_Valid,
  output logic [1:0] w_Dirty,
  output logic       w_LRU,
  output logic       Din_LRU,
  output logic       Din_Dirty,
  output logic       Din_Valid,
  output logic       data_sel,
  output logic       paddr_sel,
  output logic       way_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  logic   victim;

  logic   request;
  logic   any_hit;
  logic   hit_way;
  logic   is_miss;
  logic   victim_dirty;
  logic [1:0] hit_onehot;
  logic [1:0] victim_onehot;

  // A simultaneous read and write is treated as a write; hit0 wins over hit1.
  assign request       = mem_read | mem_write;
  assign any_hit       = hit0 | hit1;
  assign hit_way       = ~hit0;
  assign is_miss       = (state == CHECK) && request && !any_hit;
  assign victim_dirty  = lru ? dirty1 : dirty0;
  assign hit_onehot    = hit_way ? 2'b10 : 2'b01;
  assign victim_onehot = victim ? 2'b10 : 2'b01;

  // State and victim register; the victim is frozen when a miss leaves CHECK.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= CHECK;
      victim <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          if (is_miss) begin
            victim <= lru;
            state  <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (pmem_resp) state <= CHECK;
        end
        default: state <= CHECK;
      endcase
    end
  end

  // Output decode; hits and fills must act in the same cycle, so this is Mealy.
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    w_Data     = 2'b00;
    w_Tag      = 2'b00;
    w_Valid    = 2'b00;
    w_Dirty    = 2'b00;
    w_LRU      = 1'b0;
    Din_LRU    = 1'b0;
    Din_Dirty  = 1'b0;
    Din_Valid  = 1'b0;
    data_sel   = 1'b0;
    paddr_sel  = 1'b0;
    way_sel    = 1'b0;
    if (reset_n) begin
      case (state)
        CHECK: begin
          if (request) begin
            if (any_hit) begin
              mem_resp = 1'b1;
              way_sel  = hit_way;
              w_LRU    = 1'b1;
              Din_LRU  = ~hit_way;
              if (mem_write) begin
                w_Data    = hit_onehot;
                w_Dirty   = hit_onehot;
                Din_Dirty = 1'b1;
              end
            end else begin
              way_sel = lru;
            end
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          paddr_sel  = 1'b1;
          way_sel    = victim;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = victim;
          if (pmem_resp) begin
            w_Data    = victim_onehot;
            w_Tag     = victim_onehot;
            w_Valid   = victim_onehot;
            w_Dirty   = victim_onehot;
            data_sel  = 1'b1;
            Din_Valid = 1'b1;
          end
        end
        default: begin
          way_sel = 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic miss_seen;

  // Saturating counters; a hit counts only when the access never missed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      miss_seen <= 1'b0;
    end else begin
      if (is_miss) begin
        miss_seen <= 1'b1;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      if (mem_resp) begin
        miss_seen <= 1'b0;
        if (!miss_seen && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else if (state == CHECK && !request) begin
        miss_seen <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed-vector bench for cache_control with hand-computed
// expected outputs. Define CACHE_PERF_CNT_EN to also exercise the counters.
module tb_cache_control;

  logic       clk;
  logic       reset_n;
  logic       mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp;
  logic       mem_resp, pmem_read, pmem_write;
  logic [1:0] w_Data, w_Tag, w_Valid, w_Dirty;
  logic       w_LRU, Din_LRU, Din_Dirty, Din_Valid, data_sel, paddr_sel, way_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [1:0] hit_cnt, miss_cnt;
`endif

  int testCount;
  int failCount;

`ifdef CACHE_PERF_CNT_EN
  cache_control #(.CNT_WIDTH(2)) dut (
`else
  cache_control dut (
`endif
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
    .lru(lru), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .w_Data(w_Data), .w_Tag(w_Tag), .w_Valid(w_Valid), .w_Dirty(w_Dirty),
    .w_LRU(w_LRU), .Din_LRU(Din_LRU), .Din_Dirty(Din_Dirty), .Din_Valid(Din_Valid),
    .data_sel(data_sel), .paddr_sel(paddr_sel), .way_sel(way_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive all DUT inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic h0, input logic h1,
                               input logic d0, input logic d1, input logic l, input logic presp);
    mem_read  = rd;
    mem_write = wr;
    hit0      = h0;
    hit1      = h1;
    dirty0    = d0;
    dirty1    = d1;
    lru       = l;
    pmem_resp = presp;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the whole output bundle against a hand-written expectation.
  // Order: resp pread pwrite wData wTag wValid wDirty wLRU dinLRU dinDirty dinValid dataSel paddrSel waySel
  task automatic expectOuts(input string tag, input logic rsp, input logic pr, input logic pw,
                            input logic [1:0] wd, input logic [1:0] wt, input logic [1:0] wv,
                            input logic [1:0] wdy, input logic wl, input logic dl, input logic dd,
                            input logic dv, input logic ds, input logic ps, input logic ws);
    logic [17:0] act;
    logic [17:0] exp;
    act = {mem_resp, pmem_read, pmem_write, w_Data, w_Tag, w_Valid, w_Dirty,
           w_LRU, Din_LRU, Din_Dirty, Din_Valid, data_sel, paddr_sel, way_sel};
    exp = {rsp, pr, pw, wd, wt, wv, wdy, wl, dl, dd, dv, ds, ps, ws};
    checkOutput(tag, {14'd0, act}, {14'd0, exp});
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset_n   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with a hitting request pending: outputs must stay low.
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    expectOuts("reset_outputs", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
    tick();
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectOuts("idle", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);

    // Read hit in way0 (tag 0x05 idx 3 already resident)
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    expectOuts("read_hit0", 1,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0,0,0,0);

    // Write hit in way1
    tick();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    expectOuts("write_hit1", 1,0,0, 2'b10,2'b00,2'b00,2'b10, 1,0,1,0,0,0,1);

    // Read and write together act as a write
    tick();
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    expectOuts("rw_as_write", 1,0,0, 2'b01,2'b00,2'b00,2'b01, 1,1,1,0,0,0,0);

    // Illegal double hit: way0 wins
    tick();
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    expectOuts("double_hit", 1,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0,0,0,0);

    // Clean miss, victim way0; dirty1 set to show the LRU way's bit is used
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
    expectOuts("clean_miss_check", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
      expectOuts("alloc_wait", 0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
    expectOuts("alloc_fill0", 0,1,0, 2'b01,2'b01,2'b01,2'b01, 0,0,0,1,1,0,0);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 1, 0, 0);
    expectOuts("recheck_hit0", 1,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0,0,0,0);

    // Dirty miss, victim way1
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    expectOuts("dirty_miss_check", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,1);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
      expectOuts("wb_wait", 0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,1,1);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
    expectOuts("wb_done", 0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,1,1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    expectOuts("alloc1_wait", 0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
    expectOuts("alloc_fill1", 0,1,0, 2'b10,2'b10,2'b10,2'b10, 0,0,0,1,1,0,1);
    tick();
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0);
    expectOuts("recheck_hit1", 1,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0,0,0,0,0,1);

    // Reset in the middle of ALLOCATE
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    expectOuts("pre_reset_alloc", 0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
    reset_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    expectOuts("reset_in_alloc", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
    tick();
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    expectOuts("after_reset_check", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);

    // Request dropped mid-miss: fill completes, no mem_resp
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    expectOuts("drop_fill", 0,1,0, 2'b01,2'b01,2'b01,2'b01, 0,0,0,1,1,0,0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectOuts("drop_no_resp", 0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);

    // Write miss with dirty way0 victim goes to WRITEBACK
    tick();
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    expectOuts("write_miss_wb", 0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,1,0);

`ifdef CACHE_PERF_CNT_EN
    // Counters: four dropped clean misses saturate miss_cnt, then two hits
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("cnt_reset_hit", {30'd0, hit_cnt}, 32'd0);
    checkOutput("cnt_reset_miss", {30'd0, miss_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checkOutput("miss_cnt_sat", {30'd0, miss_cnt}, 32'd3);
    checkOutput("hit_cnt_after_misses", {30'd0, hit_cnt}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hit_cnt_two", {30'd0, hit_cnt}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
